// File: rtl/rng_pkg.sv
//==============================================================================
// rng_pkg : shared types and constants for the RNG health-test FIFO
// Revision: 1.0
//==============================================================================
`default_nettype none

package rng_pkg;

   localparam int RNG_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_RUN     = 2'd1,
      ST_ALARM   = 2'd2
   } rng_state_e;

endpackage

`default_nettype wire

// File: rtl/rng_sync_fifo.sv
//==============================================================================
// rng_sync_fifo : DEPTH x WIDTH first-word-fall-through FIFO with flush
// Revision: 1.0
//==============================================================================
`default_nettype none

module rng_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign pop_data  = mem_q[rd_q];
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (w_do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
         end
         if (w_do_pop) begin
            rd_d = rd_q + AW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            count_d = count_q + CW'(1);
         end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rng_health_fifo.sv
//==============================================================================
// rng_health_fifo : online health tests, start-up discard and output FIFO for
// a raw RNG stream. Optional XOR pair whitening when RNG_WHITEN_EN is defined.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rng_health_fifo
   import rng_pkg::*;
#(
   parameter int WIDTH         = RNG_WIDTH,
   parameter int DEPTH         = 8,
   parameter int STARTUP_WORDS = 16,
   parameter int REP_LIMIT     = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       raw_valid,
   input  logic [WIDTH-1:0]           raw_data,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       overflow,
   output logic                       alarm,
   input  logic                       alarm_clr
);

   localparam int SW = $clog2(STARTUP_WORDS + 1);
   localparam int RW = $clog2(REP_LIMIT);

   rng_state_e       state_q, state_d;
   logic [SW-1:0]    start_q, start_d;
   logic [RW-1:0]    rep_q, rep_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic             overflow_q, overflow_d;
   logic             alarm_q, alarm_d;

   logic             w_test, w_match, w_fail, w_pass;
   logic             w_accept, w_enter_run, w_clear_half;
   logic             w_push, w_pop;
   logic [WIDTH-1:0] w_wdata;
   logic             w_full, w_empty;

   assign w_test       = raw_valid && (state_q != ST_ALARM);
   assign w_match      = prev_valid_q && (raw_data == prev_q);
   // rep_q counts repeats beyond the first word; REP_LIMIT-2 means this word completes the run.
   assign w_fail       = w_test && ((raw_data == '0) || (w_match && (rep_q == RW'(REP_LIMIT - 2))));
   assign w_pass       = w_test && !w_fail;
   assign w_accept     = w_pass && (state_q == ST_RUN);
   assign w_enter_run  = w_pass && (state_q == ST_STARTUP) && (start_q == SW'(STARTUP_WORDS - 1));
   assign w_clear_half = w_fail || w_enter_run;
   assign w_pop        = !w_empty && out_ready;

   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      rep_d        = rep_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      if (state_q == ST_ALARM) begin
         if (alarm_clr) begin
            state_d = ST_STARTUP;
         end
      end else if (w_fail) begin
         state_d      = ST_ALARM;
         start_d      = '0;
         rep_d        = '0;
         prev_d       = '0;
         prev_valid_d = 1'b0;
      end else if (w_pass) begin
         rep_d        = w_match ? rep_q + RW'(1) : '0;
         prev_d       = raw_data;
         prev_valid_d = 1'b1;
         if (state_q == ST_STARTUP) begin
            if (w_enter_run) begin
               state_d = ST_RUN;
               start_d = '0;
            end else begin
               start_d = start_q + SW'(1);
            end
         end
      end
      alarm_d    = (state_d == ST_ALARM);
      overflow_d = overflow_q || (w_push && w_full && !w_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_STARTUP;
         start_q      <= '0;
         rep_q        <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         alarm_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         rep_q        <= rep_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         overflow_q   <= overflow_d;
         alarm_q      <= alarm_d;
      end
   end

`ifdef RNG_WHITEN_EN
   logic             half_valid_q, half_valid_d;
   logic [WIDTH-1:0] half_q, half_d;

   always_comb begin
      half_valid_d = half_valid_q;
      half_d       = half_q;
      w_push       = 1'b0;
      w_wdata      = half_q ^ raw_data;
      if (w_clear_half) begin
         half_valid_d = 1'b0;
         half_d       = '0;
      end else if (w_accept) begin
         if (half_valid_q) begin
            w_push       = 1'b1;
            half_valid_d = 1'b0;
         end else begin
            half_d       = raw_data;
            half_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_valid_q <= 1'b0;
         half_q       <= '0;
      end else begin
         half_valid_q <= half_valid_d;
         half_q       <= half_d;
      end
   end
`else
   logic w_unused_clear;

   assign w_unused_clear = w_clear_half;
   assign w_push         = w_accept;
   assign w_wdata        = raw_data;
`endif

   rng_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_wdata),
      .pop       (w_pop),
      .flush     (w_fail),
      .pop_data  (out_data),
      .full      (w_full),
      .empty     (w_empty),
      .count     (fill_level)
   );

   assign out_valid = !w_empty;
   assign overflow  = overflow_q;
   assign alarm     = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_rng_health_fifo.sv
//==============================================================================
// tb_rng_health_fifo : directed table, corner sequences and randomized traffic
// against a queue-based reference model. Honours RNG_WHITEN_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_rng_health_fifo;

   localparam int WIDTH         = 32;
   localparam int DEPTH         = 8;
   localparam int STARTUP_WORDS = 16;
   localparam int REP_LIMIT     = 4;

   logic              clk;
   logic              rst_n;
   logic              raw_valid;
   logic [WIDTH-1:0]  raw_data;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic              out_ready;
   logic [3:0]        fill_level;
   logic              overflow;
   logic              alarm;
   logic              alarm_clr;

   int n_chk  = 0;
   int n_fail = 0;

   rng_health_fifo #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .STARTUP_WORDS (STARTUP_WORDS),
      .REP_LIMIT     (REP_LIMIT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_valid  (raw_valid),
      .raw_data   (raw_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .fill_level (fill_level),
      .overflow   (overflow),
      .alarm      (alarm),
      .alarm_clr  (alarm_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: mode 0=startup 1=run 2=alarm, run length of identical words.
   int               m_mode;
   logic [WIDTH-1:0] m_q [$];
   logic [WIDTH-1:0] m_prev;
   bit               m_have_prev;
   int               m_run;
   int               m_seen;
   bit               m_ovf;
   bit               m_half_v;
   logic [WIDTH-1:0] m_half;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear_health();
      m_have_prev = 0;
      m_run       = 0;
      m_seen      = 0;
      m_half_v    = 0;
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_q.delete();
      m_ovf  = 0;
      model_clear_health();
   endtask

   task automatic model_push(input logic [WIDTH-1:0] w);
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else m_ovf = 1;
   endtask

   task automatic model_step(input bit rv, input logic [WIDTH-1:0] rd, input bit rdy, input bit clr);
      bit fail;
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (m_mode == 2) begin
         if (clr) m_mode = 0;
      end else if (rv) begin
         fail = (rd == 0) || (m_have_prev && rd == m_prev && m_run + 1 >= REP_LIMIT);
         if (fail) begin
            m_q.delete();
            m_mode = 2;
            model_clear_health();
         end else begin
            m_run       = (m_have_prev && rd == m_prev) ? m_run + 1 : 1;
            m_prev      = rd;
            m_have_prev = 1;
            if (m_mode == 0) begin
               m_seen++;
               if (m_seen == STARTUP_WORDS) begin
                  m_mode   = 1;
                  m_half_v = 0;
               end
            end else begin
`ifdef RNG_WHITEN_EN
               if (m_half_v) begin
                  model_push(m_half ^ rd);
                  m_half_v = 0;
               end else begin
                  m_half   = rd;
                  m_half_v = 1;
               end
`else
               model_push(rd);
`endif
            end
         end
      end
   endtask

   task automatic cycle(input bit rv, input logic [WIDTH-1:0] rd, input bit rdy, input bit clr);
      raw_valid = rv;
      raw_data  = rd;
      out_ready = rdy;
      alarm_clr = clr;
      @(posedge clk);
      model_step(rv, rd, rdy, clr);
      #1;
   endtask

   task automatic check_model();
      chk("valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("data", out_data, m_q[0]);
      chk("fill", 32'(fill_level), 32'(m_q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("alarm", 32'(alarm), 32'(m_mode == 2));
   endtask

   task automatic mcycle(input bit rv, input logic [WIDTH-1:0] rd, input bit rdy, input bit clr);
      cycle(rv, rd, rdy, clr);
      check_model();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      raw_valid = 1'b0;
      raw_data  = '0;
      out_ready = 1'b0;
      alarm_clr = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_fill", 32'(fill_level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_alarm", 32'(alarm), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic startup(input logic [WIDTH-1:0] base);
      for (int i = 0; i < STARTUP_WORDS; i++) mcycle(1, base + WIDTH'(i), 0, 0);
   endtask

   typedef struct {
      bit               rv;
      logic [WIDTH-1:0] rd;
      bit               rdy;
      bit               clr;
      bit               e_valid;
      logic [WIDTH-1:0] e_data;
      int               e_fill;
      bit               e_alarm;
   } vec_t;

   vec_t tbl [22];

   initial begin
      logic [WIDTH-1:0] exp_order [DEPTH];
      logic [WIDTH-1:0] last;
      int               r;

      do_reset();

`ifndef RNG_WHITEN_EN
      for (int i = 0; i < STARTUP_WORDS; i++)
         tbl[i] = '{1, 32'h100 + i, 0, 0, 0, 32'h0, 0, 0};
      tbl[16] = '{1, 32'hA5A5_0001, 0, 0, 1, 32'hA5A5_0001, 1, 0};
      tbl[17] = '{1, 32'h1234,      0, 0, 1, 32'hA5A5_0001, 2, 0};
      tbl[18] = '{1, 32'h1234,      0, 0, 1, 32'hA5A5_0001, 3, 0};
      tbl[19] = '{1, 32'h1234,      0, 0, 1, 32'hA5A5_0001, 4, 0};
      tbl[20] = '{1, 32'h1234,      0, 0, 0, 32'h0,         0, 1};
      tbl[21] = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 0};
      for (int i = 0; i < 22; i++) begin
         cycle(tbl[i].rv, tbl[i].rd, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_fill", i), 32'(fill_level), 32'(tbl[i].e_fill));
         chk($sformatf("tbl%0d_alarm", i), 32'(alarm), 32'(tbl[i].e_alarm));
         chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'd0);
      end

      // Three repeats followed by a different word must not alarm.
      startup(32'h200);
      mcycle(1, 32'h1234, 0, 0);
      mcycle(1, 32'h1234, 0, 0);
      mcycle(1, 32'h1234, 0, 0);
      mcycle(1, 32'h1235, 0, 0);
      chk("rep3_no_alarm", 32'(alarm), 32'd0);
      chk("rep3_fill", 32'(fill_level), 32'd4);

      // Zero word flushes, clear returns to startup.
      mcycle(1, 32'h0, 0, 0);
      chk("zero_alarm", 32'(alarm), 32'd1);
      chk("zero_fill", 32'(fill_level), 32'd0);
      mcycle(1, 32'h777, 1, 0);
      mcycle(0, 32'h0, 0, 1);
      chk("clr_alarm", 32'(alarm), 32'd0);
      startup(32'h300);
      chk("startup_discard", 32'(fill_level), 32'd0);

      // Overflow on the ninth word, then push+pop while full.
      for (int i = 0; i < 9; i++) mcycle(1, 32'hC000 + i, 0, 0);
      chk("full_fill", 32'(fill_level), 32'd8);
      chk("full_overflow", 32'(overflow), 32'd1);
      chk("full_head", out_data, 32'hC000);
      mcycle(1, 32'hD000, 1, 0);
      chk("pushpop_fill", 32'(fill_level), 32'd8);
      chk("pushpop_overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 7; i++) exp_order[i] = 32'hC001 + i;
      exp_order[7] = 32'hD000;
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("drain%0d", i), out_data, exp_order[i]);
         mcycle(0, 32'h0, 1, 0);
      end
      chk("drained_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-operation.
      mcycle(1, 32'hE000, 0, 0);
      mcycle(1, 32'hE001, 0, 0);
      do_reset();
`else
      startup(32'h400);
      mcycle(1, 32'hF0F0_0000, 0, 0);
      chk("wh_half_fill", 32'(fill_level), 32'd0);
      mcycle(1, 32'h0F0F_0001, 0, 0);
      chk("wh_fill", 32'(fill_level), 32'd1);
      chk("wh_data", out_data, 32'hFFFF_0001);
      mcycle(1, 32'hF0F0_0000, 0, 0);
      do_reset();
      startup(32'h500);
      mcycle(1, 32'hAAAA_0000, 0, 0);
      chk("wh_rst_half", 32'(fill_level), 32'd0);
      mcycle(1, 32'h5555_0003, 0, 0);
      chk("wh_rst_data", out_data, 32'hFFFF_0003);
      do_reset();
`endif

      // Randomized traffic against the model.
      last = 32'h1;
      for (int n = 0; n < 4000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2)       raw_data = '0;
         else if (r < 35) raw_data = last;
         else             raw_data = $urandom | 32'h1;
         last = (raw_data == 0) ? last : raw_data;
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else begin
            mcycle(($urandom_range(0, 3) != 0), raw_data,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
